data_mem_sync: RTL and testbench

Clocked, parametrised data memory for the MEM stage of the pipelined MIPS core. It replaces the combinational data memory with a synchronous array that has a registered read port and per-byte write enables. A post-reset initialisation sweep loads every word with its own address. It also reports illegal or out-of-range accesses, so the MEM stage and hazard logic can stall on `ready` and sample read data on `rd_valid`.

---
 rtl/data_mem_sync.sv | 73 +++++++
 tb/tb_data_mem_sync.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_sync.sv
// Synchronous data memory with per-byte writes, post-reset address-pattern init sweep and error flag.
// Reads return one cycle after the request edge; ready is low during the sweep, with no other backpressure.
module data_mem_sync #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] WriteData_dmem,
    input  logic [BE_W-1:0]   byte_en,
    output logic [DATA_W-1:0] ReadData_dmem,
    output logic              rd_valid,
    output logic              ready,
    output logic              err
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic in_range;
    logic is_wr;
    logic is_rd;
    logic is_bad;

    assign in_range = ({1'b0, address} < DEPTH_L);
    assign is_wr    = MemWrite && !MemRead && in_range;
    assign is_rd    = MemRead && !MemWrite && in_range;
    assign is_bad   = (MemWrite && MemRead) || ((MemWrite || MemRead) && !in_range);
    assign ready    = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            init_cnt      <= '0;
            ReadData_dmem <= '0;
            rd_valid      <= 1'b0;
            err           <= 1'b0;
        end else if (state == INIT) begin
            // Each word is seeded with its own address so software sees a known pattern.
            mem[init_cnt] <= DATA_W'(init_cnt);
            init_cnt      <= init_cnt + 1'b1;
            if (init_cnt == LAST) begin
                state <= RUN;
            end
            ReadData_dmem <= '0;
            rd_valid      <= 1'b0;
            err           <= 1'b0;
        end else begin
            rd_valid      <= is_rd;
            err           <= is_bad;
            ReadData_dmem <= is_rd ? mem[address] : '0;
            if (is_wr) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (byte_en[k]) begin
                        mem[address][8*k +: 8] <= WriteData_dmem[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: a full-depth and a 200-word instance share one stimulus stream,
// compared each cycle against a behavioural memory model plus directed literal checks.
module tb_data_mem_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [15:0] wd;
    logic [1:0]  be;

    logic [15:0] rd0, rd1;
    logic        vld0, vld1, rdy0, rdy1, err0, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut0 (
        .clk(clk), .rst(rst), .MemWrite(we), .MemRead(re), .address(addr),
        .WriteData_dmem(wd), .byte_en(be), .ReadData_dmem(rd0),
        .rd_valid(vld0), .ready(rdy0), .err(err0)
    );

    data_mem_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut1 (
        .clk(clk), .rst(rst), .MemWrite(we), .MemRead(re), .address(addr),
        .WriteData_dmem(wd), .byte_en(be), .ReadData_dmem(rd1),
        .rd_valid(vld1), .ready(rdy1), .err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: init completes DEPTH cycles after reset; then plain array semantics.
    int          dep [2] = '{256, 200};
    int          left [2];
    logic [15:0] mm [2][256];
    logic [15:0] e_rd [2];
    logic        e_vld [2];
    logic        e_err [2];
    logic        e_rdy [2];
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) model_on = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e_rd[i]  = '0;
            e_vld[i] = 1'b0;
            e_err[i] = 1'b0;
            if (rst) begin
                left[i]  = dep[i];
                e_rdy[i] = 1'b0;
            end else if (left[i] > 0) begin
                mm[i][dep[i] - left[i]] = 16'(dep[i] - left[i]);
                left[i]  = left[i] - 1;
                e_rdy[i] = (left[i] == 0);
            end else begin
                e_rdy[i] = 1'b1;
                if (we && re) begin
                    e_err[i] = 1'b1;
                end else if ((we || re) && int'(addr) >= dep[i]) begin
                    e_err[i] = 1'b1;
                end else if (we) begin
                    if (be[0]) mm[i][addr][7:0]  = wd[7:0];
                    if (be[1]) mm[i][addr][15:8] = wd[15:8];
                end else if (re) begin
                    e_vld[i] = 1'b1;
                    e_rd[i]  = mm[i][addr];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("ready0", 32'(rdy0), 32'(e_rdy[0]));
            chk("rd_valid0", 32'(vld0), 32'(e_vld[0]));
            chk("err0", 32'(err0), 32'(e_err[0]));
            chk("rdata0", 32'(rd0), 32'(e_rd[0]));
            chk("ready1", 32'(rdy1), 32'(e_rdy[1]));
            chk("rd_valid1", 32'(vld1), 32'(e_vld[1]));
            chk("err1", 32'(err1), 32'(e_err[1]));
            chk("rdata1", 32'(rd1), 32'(e_rd[1]));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] b);
        we = w; re = r; addr = a; wd = d; be = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts edges until each instance raises ready; pokes writes to address 0 early on.
    task automatic wait_ready(input int poke, output int c0, output int c1, output int errs);
        c0 = -1; c1 = -1; errs = 0;
        for (int n = 1; n <= 600 && (c0 < 0 || c1 < 0); n++) begin
            if (n <= poke) cyc(1'b1, 1'b0, 8'h00, 16'hFFFF, 2'b11);
            else           cyc(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
            if (n <= poke && (err0 || err1)) errs++;
            if (c0 < 0 && rdy0) c0 = n;
            if (c1 < 0 && rdy1) c1 = n;
        end
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
        cyc(1'b0, 1'b1, a, 16'h0000, 2'b00);
        chk({name, "_data"}, 32'(rd0), 32'(exp));
        chk({name, "_vld"}, 32'(vld0), 32'd1);
    endtask

    initial begin
        int c0, c1, ie;
        int r;
        logic [7:0] a;
        rst = 1'b1; we = 0; re = 0; addr = 0; wd = 0; be = 0;

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("reset_ready", 32'(rdy0), 32'd0);
        chk("reset_vld", 32'(vld0), 32'd0);
        chk("reset_err", 32'(err0), 32'd0);
        chk("reset_rdata", 32'(rd0), 32'd0);

        rst = 1'b0;
        wait_ready(10, c0, c1, ie);
        chk("init_latency0", 32'(c0), 32'd256);
        chk("init_latency1", 32'(c1), 32'd200);
        chk("init_ignored_err", 32'(ie), 32'd0);

        rd_chk("init_rd0", 8'h00, 16'h0000);
        rd_chk("init_rd7f", 8'h7F, 16'h007F);
        rd_chk("init_rdff", 8'hFF, 16'h00FF);

        cyc(1, 0, 8'h10, 16'hABCD, 2'b01);
        rd_chk("be_lo", 8'h10, 16'h00CD);
        cyc(1, 0, 8'h10, 16'h1234, 2'b10);
        rd_chk("be_hi", 8'h10, 16'h12CD);
        cyc(1, 0, 8'h10, 16'hFFFF, 2'b00);
        rd_chk("be_none", 8'h10, 16'h12CD);

        cyc(1, 0, 8'h05, 16'hBEEF, 2'b11);
        rd_chk("raw", 8'h05, 16'hBEEF);
        rd_chk("b2b_1", 8'h01, 16'h0001);
        rd_chk("b2b_2", 8'h02, 16'h0002);
        rd_chk("b2b_3", 8'h03, 16'h0003);

        cyc(1, 1, 8'h04, 16'h9999, 2'b11);
        chk("conflict_err", 32'(err1), 32'd1);
        chk("conflict_rdata", 32'(rd1), 32'd0);
        chk("conflict_vld", 32'(vld1), 32'd0);
        cyc(0, 1, 8'h04, 16'h0000, 2'b00);
        chk("conflict_mem", 32'(rd1), 32'h0004);
        cyc(0, 1, 8'hC8, 16'h0000, 2'b00);
        chk("oor_rd_err", 32'(err1), 32'd1);
        chk("oor_rd_vld", 32'(vld1), 32'd0);
        cyc(1, 0, 8'hFF, 16'h7777, 2'b11);
        chk("oor_wr_err", 32'(err1), 32'd1);
        chk("inrange_wr_err", 32'(err0), 32'd0);
        cyc(0, 1, 8'h37, 16'h0000, 2'b00);
        chk("no_alias", 32'(rd1), 32'h0037);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0, 1:    a = 8'($urandom_range(0, 15));
                2:       a = 8'($urandom_range(0, 255));
                default: a = 8'($urandom_range(190, 255));
            endcase
            cyc(r < 40 || (r >= 80 && r < 88), r >= 40 && r < 88, a,
                16'($urandom), 2'($urandom));
        end

        cyc(1, 0, 8'h09, 16'h5555, 2'b11);
        rst = 1'b1;
        cyc(1, 0, 8'h09, 16'hAAAA, 2'b11);
        chk("midrst_ready", 32'(rdy0), 32'd0);
        chk("midrst_rdata", 32'(rd0), 32'd0);
        rst = 1'b0;
        wait_ready(0, c0, c1, ie);
        chk("reinit_latency0", 32'(c0), 32'd256);
        chk("reinit_latency1", 32'(c1), 32'd200);
        rd_chk("reinit_rd9", 8'h09, 16'h0009);

        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int n = 0; n < 100; n++) cyc(0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        wait_ready(0, c0, c1, ie);
        chk("restart_latency0", 32'(c0), 32'd256);
        chk("restart_latency1", 32'(c1), 32'd200);
        rd_chk("restart_rd10", 8'h10, 16'h0010);
        cyc(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
